full_adder_core: RTL and testbench

Registered full-adder core: adds two WIDTH-bit operands and a 1-bit carry-in, and produces a WIDTH-bit sum and a carry-out. Internally it is a ripple chain of 1-bit full-adder cells feeding an output register with a valid flag. It is the basic arithmetic primitive for datapath blocks that need a clocked, resettable adder. With WIDTH=1 it behaves exactly as a single-bit full adder, with one cycle of latency.

---
 rtl/full_adder_core.sv | 44 ++++
 tb/tb_full_adder_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_core.sv
// Registered WIDTH-bit ripple-carry full adder with an output valid flag.
// {c, s} = x + y + z (unsigned, WIDTH+1 bits), one clock of latency.
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             out_valid
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = z;

  // Ripple chain of 1-bit full-adder cells feeding the output register.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
  end

  // Result register: load on in_valid, otherwise hold; out_valid marks a fresh result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= sum;
        c <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_core.sv
// Directed self-checking bench for full_adder_core at WIDTH=1 and WIDTH=4.
module tb_full_adder_core;

  logic       clk;
  logic       rst_n;

  logic       x1, y1, z1, v1;
  logic       s1, c1, ov1;

  logic [3:0] x4, y4;
  logic       z4, v4;
  logic [3:0] s4;
  logic       c4, ov4;

  int checks;
  int errors;

  full_adder_core #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x1),
    .y        (y1),
    .z        (z1),
    .in_valid (v1),
    .s        (s1),
    .c        (c1),
    .out_valid(ov1)
  );

  full_adder_core #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x4),
    .y        (y4),
    .z        (z4),
    .in_valid (v4),
    .s        (s4),
    .c        (c4),
    .out_valid(ov4)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock and land just after the edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x1 = 1'b0; y1 = 1'b0; z1 = 1'b0; v1 = 1'b0;
    x4 = 4'h0; y4 = 4'h0; z4 = 1'b0; v4 = 1'b0;
    step();
    step();
    checks++;
    if ({c1, s1, ov1} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_w1: got c/s/ov=%b required 000", {c1, s1, ov1});
    end
    checks++;
    if ({c4, s4, ov4} !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_w4: got c/s/ov=%b required 000000", {c4, s4, ov4});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] exp_cs [8];
    logic [2:0] vec;
    exp_cs[0] = 2'b00; exp_cs[1] = 2'b01; exp_cs[2] = 2'b01; exp_cs[3] = 2'b10;
    exp_cs[4] = 2'b01; exp_cs[5] = 2'b10; exp_cs[6] = 2'b10; exp_cs[7] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {x1, y1, z1} = vec;
      v1 = 1'b1;
      step();
      checks++;
      if ({c1, s1} !== exp_cs[i] || ov1 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL exhaustive_w1[%0d]: got cs=%b ov=%b required cs=%b ov=1",
                 i, {c1, s1}, ov1, exp_cs[i]);
      end
    end
    v1 = 1'b0;
    step();
    checks++;
    if (ov1 !== 1'b0 || {c1, s1} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL exhaustive_w1_idle: got cs=%b ov=%b required cs=11 ov=0", {c1, s1}, ov1);
    end
  endtask

  task automatic test_carry_propagation();
    x4 = 4'b1111; y4 = 4'b0000; z4 = 1'b1; v4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'b0000 || c4 !== 1'b1 || ov4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL carry_prop: got s=%h c=%b ov=%b required s=0 c=1 ov=1", s4, c4, ov4);
    end
  endtask

  task automatic test_max_result();
    x4 = 4'hF; y4 = 4'hF; z4 = 1'b1; v4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'hF || c4 !== 1'b1 || ov4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL max_result: got s=%h c=%b ov=%b required s=f c=1 ov=1", s4, c4, ov4);
    end
  endtask

  task automatic test_hold();
    x4 = 4'h1; y4 = 4'h0; z4 = 1'b0; v4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'h1 || c4 !== 1'b0 || ov4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_load: got s=%h c=%b ov=%b required s=1 c=0 ov=1", s4, c4, ov4);
    end
    v4 = 1'b0; x4 = 4'h1; y4 = 4'h1; z4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'h1 || c4 !== 1'b0 || ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_drop: got s=%h c=%b ov=%b required s=1 c=0 ov=0", s4, c4, ov4);
    end
    x4 = 4'bxxxx; y4 = 4'bxxxx; z4 = 1'bx;
    step();
    checks++;
    if (s4 !== 4'h1 || c4 !== 1'b0 || ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_xinputs: got s=%h c=%b ov=%b required s=1 c=0 ov=0", s4, c4, ov4);
    end
  endtask

  task automatic test_async_reset();
    x4 = 4'hF; y4 = 4'h1; z4 = 1'b1; v4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'h1 || c4 !== 1'b1 || ov4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_preload: got s=%h c=%b ov=%b required s=1 c=1 ov=1", s4, c4, ov4);
    end
    v4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s4 !== 4'h0 || c4 !== 1'b0 || ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got s=%h c=%b ov=%b required s=0 c=0 ov=0", s4, c4, ov4);
    end
    x4 = 4'h3; y4 = 4'h4; z4 = 1'b0; v4 = 1'b1;
    step();
    checks++;
    if (s4 !== 4'h0 || c4 !== 1'b0 || ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_discard: got s=%h c=%b ov=%b required s=0 c=0 ov=0", s4, c4, ov4);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (s4 !== 4'h7 || c4 !== 1'b0 || ov4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_recover: got s=%h c=%b ov=%b required s=7 c=0 ov=1", s4, c4, ov4);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] expected;
    for (int i = 0; i < 100; i++) begin
      x4 = 4'($urandom_range(0, 15));
      y4 = 4'($urandom_range(0, 15));
      z4 = 1'($urandom_range(0, 1));
      v4 = 1'b1;
      expected = 5'(x4) + 5'(y4) + 5'(z4);
      step();
      checks++;
      if ({c4, s4} !== expected || ov4 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream[%0d]: got cs=%h ov=%b required cs=%h ov=1",
                 i, {c4, s4}, ov4, expected);
      end
    end
    v4 = 1'b0;
    step();
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_exhaustive_w1();
    test_carry_propagation();
    test_max_result();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
